// File: rtl/multi_clkdiv_led.sv
// Multi-channel LED divider: a shared prescaler tick drives per-channel OFF/ON/BLINK/ONESHOT LEDs.
// Optional MCLKDIV_SYNC_EN adds sync_i, which realigns the prescaler and every blinking channel.
module multi_clkdiv_led #(
  parameter int unsigned CLK_HZ  = 40000000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int unsigned NCH     = 4,
  parameter int unsigned CHW     = 2,
  parameter int unsigned CW      = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [1:0]     cfg_mode,
  input  logic [CW-1:0]  cfg_half,
`ifdef MCLKDIV_SYNC_EN
  input  logic           sync_i,
`endif
  output logic           tick,
  output logic [NCH-1:0] led
);

  localparam int unsigned PRESC = CLK_HZ / TICK_HZ;
  localparam int unsigned PW    = (PRESC > 1) ? $clog2(PRESC) : 1;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ON      = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  logic [PW-1:0]  presc_q, presc_d;
  logic           tick_q, tick_d;
  logic [1:0]     mode_q [NCH];
  logic [1:0]     mode_d [NCH];
  logic [CW-1:0]  half_q [NCH];
  logic [CW-1:0]  half_d [NCH];
  logic [CW-1:0]  cnt_q  [NCH];
  logic [CW-1:0]  cnt_d  [NCH];
  logic [NCH-1:0] led_q, led_d;
  logic           sync_c;
  logic           wr_ok_c;

`ifdef MCLKDIV_SYNC_EN
  assign sync_c = sync_i;
`else
  assign sync_c = 1'b0;
`endif

  assign wr_ok_c = cfg_we && (32'(cfg_ch) < NCH);

  // Terminal count of a channel: a half-period of 0 behaves as 1.
  function automatic logic [CW-1:0] term_cnt(input logic [CW-1:0] h);
    return (h == '0) ? '0 : h - CW'(1);
  endfunction

  // Prescaler: wraps at PRESC-1 and raises the registered tick on that edge.
  always_comb begin
    presc_d = presc_q + PW'(1);
    tick_d  = 1'b0;
    if (sync_c) begin
      presc_d = '0;
    end else if (presc_q == PW'(PRESC - 1)) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end
  end

  // Channel next state: a write to the channel beats sync, which beats the tick.
  always_comb begin
    led_d = led_q;
    for (int i = 0; i < NCH; i++) begin
      mode_d[i] = mode_q[i];
      half_d[i] = half_q[i];
      cnt_d[i]  = cnt_q[i];
      if (wr_ok_c && (cfg_ch == CHW'(i))) begin
        mode_d[i] = cfg_mode;
        half_d[i] = cfg_half;
        cnt_d[i]  = '0;
        led_d[i]  = (cfg_mode == MODE_ON) || (cfg_mode == MODE_ONESHOT);
      end else if (sync_c) begin
        if (mode_q[i] == MODE_BLINK) begin
          cnt_d[i] = '0;
          led_d[i] = 1'b0;
        end else if (mode_q[i] == MODE_ONESHOT) begin
          cnt_d[i] = '0;
        end
      end else if (tick_q) begin
        case (mode_q[i])
          MODE_BLINK: begin
            if (cnt_q[i] == term_cnt(half_q[i])) begin
              cnt_d[i] = '0;
              led_d[i] = ~led_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
          MODE_ONESHOT: begin
            if (cnt_q[i] == term_cnt(half_q[i])) begin
              cnt_d[i]  = '0;
              led_d[i]  = 1'b0;
              mode_d[i] = MODE_OFF;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      led_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        mode_q[i] <= MODE_OFF;
        half_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      led_q   <= led_d;
      for (int i = 0; i < NCH; i++) begin
        mode_q[i] <= mode_d[i];
        half_q[i] <= half_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign tick = tick_q;
  assign led  = led_q;

endmodule

// File: tb/tb_multi_clkdiv_led.sv
// Bench for multi_clkdiv_led: per-cycle scoreboard against a behavioural model plus timing checks.
// Sync scenarios are exercised only when MCLKDIV_SYNC_EN is defined.
module tb_multi_clkdiv_led;

  localparam int unsigned PRESC = 10;
  localparam int unsigned NCH   = 4;
  localparam logic [1:0] M_OFF = 2'b00, M_ON = 2'b01, M_BLINK = 2'b10, M_ONE = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_ch = 3'd0;
  logic [1:0] cfg_mode = 2'b00;
  logic [3:0] cfg_half = 4'd0;
  logic       sync_s = 1'b0;
  logic       tick;
  logic [3:0] led;

  int n_checks = 0;
  int n_errors = 0;

  multi_clkdiv_led #(
    .CLK_HZ(100), .TICK_HZ(10), .NCH(NCH), .CHW(3), .CW(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_half(cfg_half),
`ifdef MCLKDIV_SYNC_EN
    .sync_i(sync_s),
`endif
    .tick(tick), .led(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference model, advanced once per rising edge.
  int         m_presc;
  logic       m_tick;
  logic [1:0] m_mode [NCH];
  int         m_half [NCH];
  int         m_cnt  [NCH];
  logic [3:0] m_led;
  logic [4:0] exp_q [$];

  task automatic model_reset();
    m_presc = 0;
    m_tick  = 1'b0;
    m_led   = '0;
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = M_OFF;
      m_half[i] = 0;
      m_cnt[i]  = 0;
    end
  endtask

  task automatic model_step();
    int lim;
    for (int i = 0; i < NCH; i++) begin
      lim = (m_half[i] == 0) ? 1 : m_half[i];
      if (cfg_we && (int'(cfg_ch) == i)) begin
        m_mode[i] = cfg_mode;
        m_half[i] = int'(cfg_half);
        m_cnt[i]  = 0;
        m_led[i]  = (cfg_mode == M_ON) || (cfg_mode == M_ONE);
      end else if (sync_s) begin
        if (m_mode[i] == M_BLINK) begin
          m_cnt[i] = 0;
          m_led[i] = 1'b0;
        end else if (m_mode[i] == M_ONE) begin
          m_cnt[i] = 0;
        end
      end else if (m_tick && (m_mode[i] == M_BLINK || m_mode[i] == M_ONE)) begin
        m_cnt[i]++;
        if (m_cnt[i] == lim) begin
          m_cnt[i] = 0;
          if (m_mode[i] == M_BLINK) begin
            m_led[i] = ~m_led[i];
          end else begin
            m_led[i]  = 1'b0;
            m_mode[i] = M_OFF;
          end
        end
      end
    end
    if (sync_s) begin
      m_presc = 0;
      m_tick  = 1'b0;
    end else begin
      m_presc++;
      m_tick = (m_presc == int'(PRESC));
      if (m_tick) m_presc = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      exp_q.push_back({m_tick, m_led});
    end
  end

  initial forever begin
    @(negedge rst_n);
    model_reset();
  end

  initial forever begin
    logic [4:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'(0), 32'(1));
    end else begin
      e = exp_q.pop_front();
      check("sb_tick_led", 32'({tick, led}), 32'(e));
    end
  end

  task automatic wr(input int ch, input logic [1:0] mode, input int half);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_ch   = 3'(ch);
    cfg_mode = mode;
    cfg_half = 4'(half);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic prev, pt;
    int   last, nt, consumed, high, n;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_led", 32'(led), 32'(0));
    check("reset_tick", 32'(tick), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Idle cadence: tick on every tenth edge, LEDs dark.
    for (int e = 1; e <= 50; e++) begin
      sample();
      check("tick_cadence", 32'(tick), 32'(e % 10 == 0));
      check("idle_led", 32'(led), 32'(0));
    end

    // BLINK half=2 on ch0: toggles every 20 cycles, one edge after a tick.
    wr(0, M_BLINK, 2);
    check("blink_start", 32'(led[0]), 32'(0));
    prev = led[0]; pt = tick; last = -1; nt = 0;
    for (int e = 1; e <= 100; e++) begin
      sample();
      if (led[0] !== prev) begin
        check("blink_after_tick", 32'(pt), 32'(1));
        if (last >= 0) check("blink_half_period", 32'(e - last), 32'(20));
        last = e;
        nt++;
      end
      prev = led[0];
      pt = tick;
    end
    check("blink_toggles", 32'(nt >= 4), 32'(1));

    // ONESHOT half=3 on ch1: high until the third tick consumed after the write.
    wr(1, M_ONE, 3);
    check("oneshot_start", 32'(led[1]), 32'(1));
    consumed = 0; pt = tick; high = 1;
    for (int e = 1; e <= 60; e++) begin
      sample();
      if (pt) consumed++;
      check("oneshot_level", 32'(led[1]), 32'(consumed < 3));
      if (led[1]) high++;
      pt = tick;
    end
    check("oneshot_high_min", 32'(high >= 21), 32'(1));
    check("oneshot_high_max", 32'(high <= 31), 32'(1));

    // ON, OFF, then a write to a nonexistent channel.
    wr(2, M_ON, 0);
    check("on_level", 32'(led[2]), 32'(1));
    repeat (3) sample();
    wr(2, M_OFF, 0);
    check("off_level", 32'(led[2]), 32'(0));
    wr(5, M_ON, 7);
    check("invalid_ch2", 32'(led[2]), 32'(0));
    check("invalid_ch1", 32'(led[1]), 32'(0));
    for (int e = 1; e <= 25; e++) begin
      sample();
      check("invalid_hold", 32'(led[2:1]), 32'(0));
    end

    // Write ch0 on the cycle tick is high: ch0 loses that tick, ch3 keeps it.
    wr(3, M_BLINK, 1);
    n = 0;
    do begin
      sample();
      n++;
    end while (tick !== 1'b1 && n < 20);
    check("tick_found", 32'(tick), 32'(1));
    cfg_we = 1'b1; cfg_ch = 3'd0; cfg_mode = M_BLINK; cfg_half = 4'd0;
    sample();
    cfg_we = 1'b0;
    check("tickwr_led0", 32'(led[0]), 32'(0));
    prev = 1'b0; last = 0; nt = 0;
    for (int e = 1; e <= 40; e++) begin
      sample();
      if (led[0] !== prev) begin
        if (nt == 0) check("tickwr_first", 32'(e), 32'(10));
        else check("tickwr_period", 32'(e - last), 32'(10));
        last = e;
        nt++;
      end
      prev = led[0];
    end
    check("tickwr_toggles", 32'(nt), 32'(4));

`ifdef MCLKDIV_SYNC_EN
    // Two blinkers started 5 cycles apart get realigned by sync.
    wr(0, M_BLINK, 1);
    repeat (5) sample();
    wr(3, M_BLINK, 1);
    repeat (3) sample();
    @(negedge clk);
    sync_s = 1'b1;
    sample();
    sync_s = 1'b0;
    check("sync_led0", 32'(led[0]), 32'(0));
    check("sync_led3", 32'(led[3]), 32'(0));
    check("sync_tick", 32'(tick), 32'(0));
    n = 0;
    do begin
      sample();
      n++;
    end while (tick !== 1'b1 && n < 20);
    check("sync_next_tick", 32'(n), 32'(10));
    sample();
    check("sync_led0_tog", 32'(led[0]), 32'(1));
    check("sync_led3_tog", 32'(led[3]), 32'(1));
`endif

    // Asynchronous reset in the middle of blinking.
    repeat (7) sample();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_led", 32'(led), 32'(0));
    check("async_rst_tick", 32'(tick), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      sample();
      check("post_rst_tick", 32'(tick), 32'(e % 10 == 0));
      check("post_rst_led", 32'(led), 32'(0));
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
